psum_drain_accumulator: RTL
===========================

Name: psum_drain_accumulator

Overview:
- Sits directly downstream of the iso-schedule multiplication stage.
- Takes each completed DIM_C x DIM_A product array from that stage and accumulates it element-wise, sign-extended and saturating, across reduction tiles.
- After the last tile, streams the accumulated array out one element per valid/ready beat to the writeback stage.
- Decouples multiplier cadence from output backpressure.

Parameters:
- DIM_A, 8, input-vector length (matches 3-bit product index)
- DIM_C, 4, weight-vector length
- ACC_WIDTH, 12, width of one incoming signed product
- OUT_WIDTH, 16, width of the accumulated signed result

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- prod_valid  in  1  product array complete this cycle
- prod_ready  out  1  block can accept a product array
- prod  in  DIM_C*DIM_A*ACC_WIDTH  packed [DIM_C][DIM_A] signed products
- tile_last  in  1  qualifies prod_valid: final tile of reduction
- out_valid  out  1  out_data holds a result element
- out_ready  in  1  downstream accepts element
- out_data  out  OUT_WIDTH  signed accumulated element
- out_idx  out  $clog2(DIM_C*DIM_A)  element index, c*DIM_A + a
- out_last  out  1  final element of the array
- sat_flag  out  1  sticky: any saturation in the current reduction

Behaviour:
- Reset: one clock, clk; asynchronous active-low reset, rst_n.
- On rst_n low:
  - state=ACCUM, first_tile=1, accumulators=0, drain index=0, sat_flag=0.
  - out_valid=0, out_data=0, out_idx=0, out_last=0.
  - prod_ready=1 once rst_n deasserts.
- Reset mid-drain aborts the drain; no further beats are emitted.
- States: ACCUM, DRAIN.
- ACCUM:
  - prod_ready=1, out_valid=0.
  - On prod_valid: acc[c][a] <= sat(base + sext(prod[c][a])), where base = 0 if first_tile else acc[c][a].
  - first_tile <= 0.
  - If first_tile, sat_flag is cleared, then ORed with this update's saturation.
  - If tile_last also: state<=DRAIN, drain index<=0.
  - Single-tile reduction is legal (first_tile and tile_last together).
- DRAIN:
  - prod_ready=0; prod_valid is ignored and accumulators are unchanged.
  - out_valid=1 from the first DRAIN cycle; out_data=acc at out_idx.
  - out_last=(out_idx==DIM_C*DIM_A-1).
  - On out_valid && out_ready: idx++.
  - On the transfer with out_last: state<=ACCUM, first_tile<=1, idx<=0.
  - Outputs are held stable while out_ready=0.
  - sat_flag is held through the drain.
- Latency: the first element is valid the cycle after the accepting edge of the tile_last array. Minimum drain is DIM_C*DIM_A cycles. Zero-bubble return: prod_ready=1 the cycle after the last beat.
- Arithmetic: OUT_WIDTH-bit signed add. Result clamps to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. Overflow is detected by operand and result signs.
- All elements update in parallel in one cycle.

Decomposition:
- Shared package: DIM_A, DIM_C, ACC_WIDTH, OUT_WIDTH, IDX_WIDTH, the state enum {ACCUM, DRAIN}, and typedefs prod_arr_t and acc_arr_t.
- One natural sub-module: sat_add_signed (OUT_WIDTH operands; sum plus overflow bit), instantiated DIM_C*DIM_A times via generate.

Test Plan (defaults):
- Reset: release rst_n -> out_valid=0, prod_ready=1, sat_flag=0, out_idx=0.
- Single tile: prod[c][a]=c*8+a, tile_last=1 -> 32 beats with out_data=out_idx=0..31, out_last only on beat 31, prod_ready=1 the next cycle.
- Three tiles of 12'h7FF (last with tile_last), then one new tile of 12'h800 -> first drain all 6141; second drain all -2048 (first_tile clear verified), sat_flag=0.
- Saturation:
  - 17 tiles of 12'h7FF -> all 32767, sat_flag=1.
  - 17 tiles of 12'h800 -> all -32768, sat_flag=1.
  - Next 1-tile reduction of 1 -> sat_flag=0.
- Backpressure: out_ready pattern 1,0,0,1 repeating; prod_valid=1 throughout DRAIN with value 5 -> out_data/out_idx stable during stalls, drain values unchanged, next reduction equals only post-drain tiles.
- Reset mid-drain at beat 10 -> out_valid=0 next cycle; following 1-tile reduction of 3 drains all 3 from out_idx=0.

Source files
------------

// File: rtl/psum_drain_accumulator_pkg.sv
// Shared sizes, state encoding and array types for the partial-sum drain accumulator.
package psum_drain_accumulator_pkg;

  localparam int DIM_A     = 8;
  localparam int DIM_C     = 4;
  localparam int ACC_WIDTH = 12;
  localparam int OUT_WIDTH = 16;
  localparam int NUM_EL    = DIM_C * DIM_A;
  localparam int IDX_WIDTH = $clog2(NUM_EL);

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Element [c][a] sits at bit offset (c*DIM_A + a) * width in both arrays.
  typedef logic signed [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0] prod_arr_t;
  typedef logic signed [DIM_C-1:0][DIM_A-1:0][OUT_WIDTH-1:0] acc_arr_t;

endpackage

// File: rtl/psum_drain_accumulator_sat_add.sv
// Signed saturating adder: clamps to the representable range and flags overflow.
module sat_add_signed #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         ovf_o
);

  logic [W-1:0] raw;
  logic [W-1:0] max_pos;
  logic [W-1:0] min_neg;

  assign raw     = a_i + b_i;
  assign max_pos = {1'b0, {(W-1){1'b1}}};
  assign min_neg = {1'b1, {(W-1){1'b0}}};

  // Overflow only when both operands share a sign the result does not.
  always_comb begin
    ovf_o = (a_i[W-1] == b_i[W-1]) && (raw[W-1] != a_i[W-1]);
    sum_o = raw;
    if (ovf_o) sum_o = a_i[W-1] ? min_neg : max_pos;
  end

endmodule

// File: rtl/psum_drain_accumulator.sv
// Accumulates product arrays across reduction tiles, then streams the
// saturated sums out one element per valid/ready beat.
module psum_drain_accumulator
  import psum_drain_accumulator_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                prod_valid,
  output logic                                prod_ready,
  input  logic [DIM_C*DIM_A*ACC_WIDTH-1:0]    prod,
  input  logic                                tile_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [OUT_WIDTH-1:0]                out_data,
  output logic [IDX_WIDTH-1:0]                out_idx,
  output logic                                out_last,
  output logic                                sat_flag
);

  state_e                 state_q, state_d;
  logic                   first_tile_q, first_tile_d;
  acc_arr_t               acc_q, acc_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic                   sat_q, sat_d;

  prod_arr_t              prod_arr;
  acc_arr_t               sum_arr;
  logic [NUM_EL-1:0]      ovf;
  logic                   sat_any;
  logic [NUM_EL-1:0][OUT_WIDTH-1:0] acc_flat;
  logic                   last_el;

  assign prod_arr = prod;
  assign acc_flat = acc_q;
  assign sat_any  = |ovf;
  assign last_el  = (idx_q == IDX_WIDTH'(NUM_EL - 1));

  // One saturating adder per element; the first tile of a reduction adds to zero.
  for (genvar c = 0; c < DIM_C; c++) begin : g_c
    for (genvar a = 0; a < DIM_A; a++) begin : g_a
      logic [OUT_WIDTH-1:0] base;
      logic [OUT_WIDTH-1:0] addend;
      assign base   = first_tile_q ? '0 : acc_q[c][a];
      assign addend = {{(OUT_WIDTH-ACC_WIDTH){prod_arr[c][a][ACC_WIDTH-1]}}, prod_arr[c][a]};
      sat_add_signed #(.W(OUT_WIDTH)) u_add (
        .a_i   (base),
        .b_i   (addend),
        .sum_o (sum_arr[c][a]),
        .ovf_o (ovf[c*DIM_A+a])
      );
    end
  end

  // State, accumulators, drain index and sticky saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACCUM;
      first_tile_q <= 1'b1;
      acc_q        <= '0;
      idx_q        <= '0;
      sat_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      first_tile_q <= first_tile_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      sat_q        <= sat_d;
    end
  end

  // Next-state: accumulate on accepted arrays, then walk the index while draining.
  always_comb begin
    state_d      = state_q;
    first_tile_d = first_tile_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    sat_d        = sat_q;
    case (state_q)
      ACCUM: begin
        if (prod_valid) begin
          acc_d        = sum_arr;
          first_tile_d = 1'b0;
          sat_d        = (first_tile_q ? 1'b0 : sat_q) | sat_any;
          if (tile_last) begin
            state_d = DRAIN;
            idx_d   = '0;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (last_el) begin
            state_d      = ACCUM;
            first_tile_d = 1'b1;
            idx_d        = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  assign prod_ready = (state_q == ACCUM);
  assign out_valid  = (state_q == DRAIN);
  assign out_data   = out_valid ? acc_flat[idx_q] : '0;
  assign out_idx    = idx_q;
  assign out_last   = out_valid && last_el;
  assign sat_flag   = sat_q;

endmodule
